// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer
//   Turns ball/paddle positions (field cells) into VGA-style raster timing
//   and a 1-bit monochrome pixel stream. Each field cell is a 2x2 pixel
//   block placed at (FIELD_X0, FIELD_Y0). A once-per-frame tick is issued
//   at the start of vertical blank and the positions are snapshotted on
//   that tick, so every displayed frame uses one consistent set of values.
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   ball_x, ball_y           ball position, cells
//   left_paddle_y            left paddle centre row, cells
//   right_paddle_y           right paddle centre row, cells
//   state_valid              positions may be captured at the tick
//   frame_tick               one-cycle pulse per frame (game update strobe)
//   hsync, vsync             active-low syncs
//   display_en               visible area
//   pixel                    1 = lit
// All outputs are registered: they reflect the counters of the previous cycle.
module pong_vga_renderer #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int FIELD_X0      = 120,
  parameter int FIELD_Y0      = 53,
  parameter int SCREEN_WIDTH  = 200,
  parameter int SCREEN_HEIGHT = 187,
  parameter int PADDLE_EXTENT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ball_x,
  input  logic [7:0] ball_y,
  input  logic [7:0] left_paddle_y,
  input  logic [7:0] right_paddle_y,
  input  logic       state_valid,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       pixel
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] FX_START = 10'(FIELD_X0);
  localparam logic [9:0] FX_END   = 10'(FIELD_X0 + 2 * SCREEN_WIDTH);
  localparam logic [9:0] FY_START = 10'(FIELD_Y0);
  localparam logic [9:0] FY_END   = 10'(FIELD_Y0 + 2 * SCREEN_HEIGHT);
  localparam logic [7:0] COL_LIMIT = 8'(SCREEN_WIDTH);
  localparam logic [7:0] ROW_LIMIT = 8'(SCREEN_HEIGHT);
  localparam logic [7:0] LEFT_COL  = 8'd1;
  localparam logic [7:0] RIGHT_COL = 8'(SCREEN_WIDTH - 2);
  localparam logic [7:0] NET_COL   = 8'(SCREEN_WIDTH / 2);
  localparam logic signed [8:0] EXT = 9'(PADDLE_EXTENT);

  // Row test done in 9-bit signed so a paddle near row 0 never wraps to 255.
  function automatic logic paddle_hit(input logic [7:0] row, input logic [7:0] centre);
    logic signed [8:0] diff;
    diff = $signed({1'b0, row}) - $signed({1'b0, centre});
    return (diff <= EXT) && (diff >= -EXT);
  endfunction

  logic [9:0] h;
  logic [9:0] v;

  logic [7:0] shadow_ball_x;
  logic [7:0] shadow_ball_y;
  logic [7:0] shadow_left_y;
  logic [7:0] shadow_right_y;

  logic       tick_p0;
  logic       hsync_p0;
  logic       vsync_p0;
  logic       display_p0;
  logic       in_field_p0;
  logic [7:0] fx_p0;
  logic [7:0] fy_p0;
  logic       ball_hit_p0;
  logic       lit_p0;

  // Raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Stage p0: decode from current counters
  always_comb begin
    tick_p0     = (h == '0) && (v == V_VIS);
    hsync_p0    = !((h >= HS_START) && (h < HS_END));
    vsync_p0    = !((v >= VS_START) && (v < VS_END));
    display_p0  = (h < H_VIS) && (v < V_VIS);
    in_field_p0 = (h >= FX_START) && (h < FX_END) && (v >= FY_START) && (v < FY_END);
    fx_p0       = 8'((h - FX_START) >> 1);
    fy_p0       = 8'((v - FY_START) >> 1);
    ball_hit_p0 = (shadow_ball_x < COL_LIMIT) && (shadow_ball_y < ROW_LIMIT) &&
                  (fx_p0 == shadow_ball_x) && (fy_p0 == shadow_ball_y);
    lit_p0      = ball_hit_p0 ||
                  ((fx_p0 == LEFT_COL)  && paddle_hit(fy_p0, shadow_left_y))  ||
                  ((fx_p0 == RIGHT_COL) && paddle_hit(fy_p0, shadow_right_y)) ||
                  ((fx_p0 == NET_COL)   && !fy_p0[2]);
  end

  // Position snapshot, taken only on the frame tick
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_ball_x  <= '0;
      shadow_ball_y  <= '0;
      shadow_left_y  <= '0;
      shadow_right_y <= '0;
    end else if (tick_p0 && state_valid) begin
      shadow_ball_x  <= ball_x;
      shadow_ball_y  <= ball_y;
      shadow_left_y  <= left_paddle_y;
      shadow_right_y <= right_paddle_y;
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_en <= 1'b0;
      pixel      <= 1'b0;
    end else begin
      frame_tick <= tick_p0;
      hsync      <= hsync_p0;
      vsync      <= vsync_p0;
      display_en <= display_p0;
      pixel      <= display_p0 && in_field_p0 && lit_p0;
    end
  end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Scoreboarded bench for pong_vga_renderer, using a reduced raster and
// field so several frames fit in a short run.
module tb_pong_vga_renderer;

  localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
  localparam int X0 = 4, Y0 = 3, SW = 16, SH = 12, EXT = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  logic       clk;
  logic       rst;
  logic [7:0] ball_x, ball_y, left_paddle_y, right_paddle_y;
  logic       state_valid;
  logic       frame_tick, hsync, vsync, display_en, pixel;

  pong_vga_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .FIELD_X0(X0), .FIELD_Y0(Y0), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
    .PADDLE_EXTENT(EXT)
  ) dut (
    .clk(clk), .rst(rst),
    .ball_x(ball_x), .ball_y(ball_y),
    .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
    .state_valid(state_valid),
    .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync),
    .display_en(display_en), .pixel(pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: counters of the DUT in the current cycle and its snapshot
  int mh = 0, mv = 0;
  int sbx = 0, sby = 0, slp = 0, srp = 0;
  int cyc = 0;
  int first_tick = -1;
  int tick_cnt = 0;
  logic [4:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (h=%0d v=%0d cyc=%0d)", tag, got, exp, mh, mv, cyc);
    end
  endtask

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // expected {frame_tick, hsync, vsync, display_en, pixel} for position (h,v)
  function automatic logic [4:0] model(input int h, input int v);
    logic de, hs, vs, tk, inf, lit;
    int fx, fy;
    de  = (h < HA) && (v < VA);
    hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
    vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    tk  = (h == 0) && (v == VA);
    inf = (h >= X0) && (h < X0 + 2 * SW) && (v >= Y0) && (v < Y0 + 2 * SH);
    fx  = (h - X0) / 2;
    fy  = (v - Y0) / 2;
    lit = (fx == sbx && fy == sby) ||
          (fx == 1 && iabs(fy - slp) <= EXT) ||
          (fx == SW - 2 && iabs(fy - srp) <= EXT) ||
          (fx == SW / 2 && (fy % 8) < 4);
    return {tk, hs, vs, de, de && inf && lit};
  endfunction

  task automatic step();
    logic [4:0] got;
    sb.push_back(rst ? 5'b01100 : model(mh, mv));
    @(posedge clk);
    #1;
    got = {frame_tick, hsync, vsync, display_en, pixel};
    check("out", {27'd0, got}, {27'd0, sb.pop_front()});
    if (rst) begin
      mh = 0; mv = 0;
      sbx = 0; sby = 0; slp = 0; srp = 0;
    end else begin
      if (mh == 0 && mv == VA && state_valid) begin
        sbx = ball_x; sby = ball_y; slp = left_paddle_y; srp = right_paddle_y;
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    cyc++;
    if (frame_tick) begin
      tick_cnt++;
      if (first_tick < 0) first_tick = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // bounded: advance until model row reaches target (at h==0)
  task automatic run_to_row(input int row);
    int k;
    k = 0;
    while (!(mv == row && mh == 0) && k < 2 * FT) begin
      step();
      k++;
    end
    check("row_reach", {31'd0, k < 2 * FT}, 32'd1);
  endtask

  initial begin
    int ticks_before;
    rst = 1'b1;
    ball_x = 8'd0; ball_y = 8'd0;
    left_paddle_y = 8'd0; right_paddle_y = 8'd0;
    state_valid = 1'b0;
    run(3);
    rst = 1'b0;
    cyc = 0;
    tick_cnt = 0;
    first_tick = -1;

    // ball only, paddles off-field
    state_valid = 1'b1;
    ball_x = 8'd3; ball_y = 8'd4;
    left_paddle_y = 8'd200; right_paddle_y = 8'd200;
    run(2 * FT);
    check("first_tick", first_tick, VA * HT + 1);
    check("tick_cnt", tick_cnt, 2);

    // paddles, right one at row 0 (no wrap)
    left_paddle_y = 8'd5; right_paddle_y = 8'd0;
    run(FT);

    // mid-frame change: current frame keeps old snapshot
    run_to_row(5);
    ball_x = 8'd7; ball_y = 8'd9;
    run(FT + HT);

    // state_valid low at the tick: image held
    state_valid = 1'b0;
    ball_x = 8'd1; ball_y = 8'd1; left_paddle_y = 8'd8;
    run(FT);

    // out-of-range ball positions
    state_valid = 1'b1;
    ball_x = 8'd20; ball_y = 8'd4;
    run(FT);
    ball_x = 8'd5; ball_y = 8'd12;
    run(FT);

    // reset mid-frame: restart, no tick, snapshot cleared
    run_to_row(10);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    cyc = 0;
    ticks_before = tick_cnt;
    run(VA * HT);
    check("no_tick_after_rst", tick_cnt, ticks_before);
    run(FT);
    check("tick_resume", tick_cnt, ticks_before + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_vga_renderer.md
Name: pong_vga_renderer

Overview:
- Downstream consumer of the pong game-state block. Takes ball and paddle positions in field coordinates (200x187) and generates 640x480 VGA-style raster timing with a 1-bit monochrome pixel stream.
- Each game cell is drawn as a 2x2 pixel block, offset into the active area.
- Emits a once-per-frame tick that the game-state block uses as its update strobe.
- Snapshots the positions at that tick so each displayed frame is tear-free.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- FIELD_X0, 120, first pixel column of the game field
- FIELD_Y0, 53, first pixel line of the game field
- SCREEN_WIDTH, 200, field width in cells
- SCREEN_HEIGHT, 187, field height in cells
- PADDLE_EXTENT, 5, paddle half-height in cells

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active high
- ball_x  in  8  ball column, cells
- ball_y  in  8  ball row, cells
- left_paddle_y  in  8  left paddle centre row
- right_paddle_y  in  8  right paddle centre row
- state_valid  in  1  positions are valid for capture
- frame_tick  out  1  one-cycle pulse per frame; game-state update strobe
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_en  out  1  high during visible area
- pixel  out  1  1 = lit

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active high.
- Counters:
  - h is 10 bits, counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - v is 10 bits, counts 0..V_TOTAL-1, where V_TOTAL = 525. v increments only when h wraps to 0.
  - At h=799, v=524 both counters wrap to 0.
- Reset:
  - Counters go to (0,0); snapshot registers go to 0.
  - Outputs: hsync=1, vsync=1, display_en=0, pixel=0, frame_tick=0.
  - The first cycle after rst deasserts has counters at (0,0).
  - rst asserted mid-frame aborts the frame and restarts at (0,0) with no frame_tick.
- Output latency: every output is registered and reflects the counter value of the previous cycle (1-cycle latency, identical for all outputs).
- Sync and display decode:
  - hsync=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync=0 iff 490 <= v < 492.
  - display_en = (h<640) && (v<480).
- frame_tick: decoded at h=0, v=V_ACTIVE (start of vertical blank). Exactly one pulse per frame.
- Snapshot:
  - In the cycle the frame_tick condition is decoded, if state_valid=1, all four position inputs load into shadow registers. If state_valid=0, the shadow registers hold.
  - Drawing uses only the shadow values, so input changes at any other time are invisible until the next tick.
- Field mapping:
  - in_field = h >= FIELD_X0 && h < FIELD_X0+2*SCREEN_WIDTH && v >= FIELD_Y0 && v < FIELD_Y0+2*SCREEN_HEIGHT.
  - fx = (h-FIELD_X0)>>1 and fy = (v-FIELD_Y0)>>1, both 8 bits.
- Pixel lit iff display_en && in_field && any of:
  - ball: fx==ball_x && fy==ball_y.
  - left paddle: fx==1 && |fy-left_paddle_y| <= PADDLE_EXTENT. Difference is computed as a 9-bit signed value (no 8-bit wrap).
  - right paddle: fx==SCREEN_WIDTH-2 with the same row rule.
  - centre net: fx==SCREEN_WIDTH/2 && fy[2]==0.
- Out-of-range inputs are never drawn and cause no error:
  - ball_x >= SCREEN_WIDTH or ball_y >= SCREEN_HEIGHT.
  - Paddle rows beyond the field are clipped by in_field.
- Overlapping objects: logical OR, no priority.

Test Plan:
- Reset/timing: rst held 3 cycles, released → outputs at reset values for the first post-reset cycle. hsync low for exactly 96 consecutive cycles per 800-cycle line, first falling 657 cycles after release. vsync low for 1600 cycles per 420000-cycle frame.
- frame_tick: free run 3 frames → exactly one 1-cycle pulse every 420000 cycles, first at 480*800+1 cycles after release. display_en high for 640*480 cycles per frame.
- Ball draw: state_valid=1, ball=(10,20), paddles=200 (off-field) → after the next tick, pixel high only at h=140..141, v=93..94, plus net pixels (h=320..321, fy[2]==0 rows).
- Paddles: left=50, right=0 → left lit at h=122..123, v=143..164. Right lit at h=516..517, v=53..64 (rows 0..5 only, no wrap to rows 250+).
- Snapshot and state_valid: change ball to (30,30) mid-frame → the current frame still draws (10,20), the next frame draws (30,30). With state_valid=0 at the tick and new inputs, the old image is kept.
- Reset mid-frame at v=200 → counters restart, no frame_tick, snapshot cleared (ball drawn at (0,0)).
